fip_32_div_seq: RTL and testbench
=================================

// Module: fip_32_div_seq
// PURPOSE
// Sequential signed Q16.16 divider: quot = (x << FRAC_BITS) / y, one quotient bit per clock.
// Completes the fixed-point arithmetic set beside fip_32_adder/fip_32_sub/fip_32_mult.
// Feeds ray-intersection math (t = num/den, normalisation).
// Valid/ready handshake on both sides; one division in flight at a time.
// PARAMETERS
// WIDTH      32  operand/result width, two's complement
// FRAC_BITS  16  fractional bits (Q16.16)
// ITERS      WIDTH+FRAC_BITS (48), derived localparam, one iteration per cycle
// PORTS
// clk          in   1      rising-edge clock
// reset        in   1      synchronous, active-high
// in_valid     in   1      x/y valid
// in_ready     out  1      block can accept operands
// x            in   WIDTH  signed dividend, Q16.16
// y            in   WIDTH  signed divisor, Q16.16
// out_valid    out  1      quot/flags valid
// out_ready    in   1      consumer accepts result
// quot         out  WIDTH  signed quotient, Q16.16
// overflow     out  1      result saturated (includes divide-by-zero)
// div_by_zero  out  1      y was 0
// BEHAVIOUR
// - One clock domain; all state changes on rising clk. reset=1 forces state IDLE, counter 0.
// - Reset values: in_ready=1, out_valid=0, quot=0, overflow=0, div_by_zero=0. All datapath regs cleared.
// - Reset mid-operation aborts the division; no result is produced.
// - States: IDLE -> CALC -> FIX -> DONE -> IDLE.
// - IDLE: in_ready=1. On in_valid&&in_ready, latch:
//   - sign = x[31]^y[31]
//   - |x| and |y| as WIDTH-bit unsigned; 0x80000000 -> 2^31, no wrap.
//   - If y==0: go to DONE with div_by_zero=1, overflow=1; quot=0x7FFFFFFF if x>=0, else 0x80000000.
//   - Otherwise: dividend = |x| << FRAC_BITS (48b), remainder=0, cnt=0, go to CALC.
// - CALC: restoring division, MSB first, one bit per cycle.
//   - rem = {rem, dividend MSB}; if rem >= |y|, subtract |y| and shift in q=1, else q=0.
//   - Remainder is WIDTH+1 bits.
//   - After ITERS cycles (cnt==ITERS-1), go to FIX.
// - FIX (1 cycle): 48-bit unsigned magnitude q; rounding is truncation toward zero.
//   - sign=0: q>0x7FFFFFFF -> quot=0x7FFFFFFF, overflow=1; else quot=q.
//   - sign=1: q>0x80000000 -> quot=0x80000000, overflow=1; else quot=-q.
//     q==0x80000000 is exact; overflow=0.
//   - Go to DONE.
// - DONE: out_valid=1; quot/overflow/div_by_zero held stable while out_valid&&!out_ready.
//   - On out_ready: out_valid=0, go to IDLE.
//   - in_ready=0 in DONE; no same-cycle accept.
// - in_ready=0 in CALC/FIX/DONE; in_valid there is ignored, operands not sampled.
// - Latency: accept edge N -> out_valid high after edge N+ITERS+1 (49 cycles); y==0 -> after edge N.
// - Throughput: at most one result per ITERS+3 cycles.
// - Flags are meaningful only while out_valid=1. A zero quotient is never negative (-0 -> 0).
// TESTING
// 1) x=0x00010000, y=0x00010000 -> quot=0x00010000, overflow=0, out_valid exactly 49 cycles after accept.
// 2) x=0xFFFD0000 (-3.0), y=0x00020000 -> quot=0xFFFE8000 (-1.5).
//    x=0x00010000, y=0x00030000 -> quot=0x00005555 (truncated).
// 3) x=0x40000000, y=0x00000001 -> quot=0x7FFFFFFF, overflow=1.
//    x=0x80000000, y=0x00010000 -> quot=0x80000000, overflow=0.
// 4) y=0, x=0xFFFF0000 -> after 1 cycle: quot=0x80000000, div_by_zero=1, overflow=1.
// 5) Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; in_valid pulses ignored.
//    Next accepted op yields the correct new result.
// 6) Assert reset at CALC cycle 20 -> next cycle in_ready=1, out_valid=0, all outputs 0.
//    A following 1.0/1.0 still returns 0x00010000.

Source files
------------

// File: rtl/fip_32_div_seq.sv
// Sequential signed Q16.16 divider: quot = (x << FRAC_BITS) / y, one quotient bit per clock.
// Restoring division on operand magnitudes, with saturation and divide-by-zero flagging.
module fip_32_div_seq #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned FRAC_BITS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quot,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam int unsigned ITERS = WIDTH + FRAC_BITS;
   localparam int unsigned CW    = $clog2(ITERS + 1);
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [ITERS-1:0]   div_r, div_n;
   logic [WIDTH:0]     rem_r, rem_n;
   logic [WIDTH-1:0]   ymag, ymag_n;
   logic               sign_r, sign_n;
   logic               in_ready_n, out_valid_n, overflow_n, dbz_n;
   logic [WIDTH-1:0]   quot_n;

   logic [WIDTH-1:0]   x_abs, y_abs;
   logic [WIDTH:0]     rem_sh, rem_sub;

   // Magnitudes as unsigned: the most negative value maps to 2^(WIDTH-1) without wrapping.
   assign x_abs = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
   assign y_abs = y[WIDTH-1] ? (~y + WIDTH'(1)) : y;

   // Partial remainder always stays below |y|, so dropping the top bit on the shift is safe.
   assign rem_sh  = (WIDTH+1)'({rem_r, div_r[ITERS-1]});
   assign rem_sub = rem_sh - {1'b0, ymag};

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         div_r       <= '0;
         rem_r       <= '0;
         ymag        <= '0;
         sign_r      <= 1'b0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quot        <= '0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         div_r       <= div_n;
         rem_r       <= rem_n;
         ymag        <= ymag_n;
         sign_r      <= sign_n;
         in_ready    <= in_ready_n;
         out_valid   <= out_valid_n;
         quot        <= quot_n;
         overflow    <= overflow_n;
         div_by_zero <= dbz_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      div_n       = div_r;
      rem_n       = rem_r;
      ymag_n      = ymag;
      sign_n      = sign_r;
      in_ready_n  = in_ready;
      out_valid_n = out_valid;
      quot_n      = quot;
      overflow_n  = overflow;
      dbz_n       = div_by_zero;

      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               in_ready_n = 1'b0;
               sign_n     = x[WIDTH-1] ^ y[WIDTH-1];
               ymag_n     = y_abs;
               if (y == '0) begin
                  state_n     = DONE;
                  out_valid_n = 1'b1;
                  dbz_n       = 1'b1;
                  overflow_n  = 1'b1;
                  quot_n      = x[WIDTH-1] ? MIN_NEG : MAX_POS;
               end else begin
                  div_n   = {x_abs, {FRAC_BITS{1'b0}}};
                  rem_n   = '0;
                  cnt_n   = '0;
                  state_n = CALC;
               end
            end
         end

         // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
         CALC: begin
            if (rem_sh >= {1'b0, ymag}) begin
               rem_n = rem_sub;
               div_n = {div_r[ITERS-2:0], 1'b1};
            end else begin
               rem_n = rem_sh;
               div_n = {div_r[ITERS-2:0], 1'b0};
            end
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(ITERS - 1)) begin
               state_n = FIX;
            end
         end

         FIX: begin
            dbz_n       = 1'b0;
            overflow_n  = 1'b0;
            out_valid_n = 1'b1;
            state_n     = DONE;
            if (!sign_r) begin
               if (div_r > ITERS'(MAX_POS)) begin
                  quot_n     = MAX_POS;
                  overflow_n = 1'b1;
               end else begin
                  quot_n = div_r[WIDTH-1:0];
               end
            end else begin
               if (div_r > ITERS'(MIN_NEG)) begin
                  quot_n     = MIN_NEG;
                  overflow_n = 1'b1;
               end else begin
                  quot_n = -div_r[WIDTH-1:0];
               end
            end
         end

         DONE: begin
            if (out_ready) begin
               out_valid_n = 1'b0;
               in_ready_n  = 1'b1;
               state_n     = IDLE;
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fip_32_div_seq.sv
// Testbench for fip_32_div_seq: directed corner cases plus random operands
// checked against a 64-bit integer arithmetic reference.
module tb_fip_32_div_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic [31:0] y;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quot;
   logic        overflow;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;

   fip_32_div_seq dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .x           (x),
      .y           (y),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quot        (quot),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: exact signed quotient of x*2^16 / y, truncated toward zero, then saturated.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic ov, output logic dz);
      longint n, d, r;
      if (b == 32'd0) begin
         q  = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         ov = 1'b1;
         dz = 1'b1;
      end else begin
         n  = longint'($signed(a)) * 64'sd65536;
         d  = longint'($signed(b));
         r  = n / d;
         dz = 1'b0;
         if (r > 64'sd2147483647) begin
            q  = 32'h7FFF_FFFF;
            ov = 1'b1;
         end else if (r < -64'sd2147483648) begin
            q  = 32'h8000_0000;
            ov = 1'b1;
         end else begin
            q  = 32'(r);
            ov = 1'b0;
         end
      end
   endfunction

   // One transaction from the negedge: accept, measure latency, hold result, release.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic eov, input logic edz,
                         input int hold);
      int n;
      int lat;
      int elat;
      elat = (b == 32'd0) ? 0 : 49;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_ready", 32'(in_ready), 32'd1);
      x = a;
      y = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 100) begin
         in_valid = 1'($urandom_range(0, 1));
         x = $urandom;
         y = $urandom;
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check("latency", 32'(lat), 32'(elat));
      check("quot", quot, eq);
      check("overflow", 32'(overflow), 32'(eov));
      check("div_by_zero", 32'(div_by_zero), 32'(edz));
      check("done_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         x = $urandom;
         y = $urandom;
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_quot", quot, eq);
         check("hold_flags", {30'd0, overflow, div_by_zero}, {30'd0, eov, edz});
         check("hold_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic run_rand(input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] q;
      logic ov, dz;
      model(a, b, q, ov, dz);
      run_op(a, b, q, ov, dz, hold);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      y         = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_quot", quot, 32'd0);
      check("rst_flags", {30'd0, overflow, div_by_zero}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed values with hand-derived expectations.
      run_op(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 0);
      run_op(32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, 1'b0, 1);
      run_op(32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 0);
      run_op(32'h4000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);
      run_op(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
      run_op(32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);
      run_op(32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 0);
      run_op(32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
      run_op(32'hFFFF_FFFF, 32'h0100_0000, 32'h0000_0000, 1'b0, 1'b0, 0);
      run_op(32'h0003_0000, 32'hFFFE_0000, 32'hFFFE_8000, 1'b0, 1'b0, 10);
      run_op(32'h0002_0000, 32'h0001_0000, 32'h0002_0000, 1'b0, 1'b0, 0);

      // Abort mid-division by reset.
      x = 32'h0001_0000;
      y = 32'h0001_0000;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_ready", 32'(in_ready), 32'd1);
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_quot", quot, 32'd0);
      check("abort_flags", {30'd0, overflow, div_by_zero}, 32'd0);
      run_op(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 0);

      // Random operands across magnitudes, with occasional zero divisors.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) ra = -ra;
         rb = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) rb = -rb;
         if ($urandom_range(0, 15) == 0) rb = 32'd0;
         run_rand(ra, rb, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
